// File: rtl/fft_pkg.sv
// Shared types and helpers for the R22SDF FFT stages: FSM encodings and complex word handling.
// Complex words are packed {real, imag}; helpers widen each half to a signed cval_t.
package fft_pkg;

  localparam int HMAX = 32;

  typedef logic signed [HMAX:0] cval_t;
  typedef logic [2*HMAX-1:0]    word_t;

  typedef struct packed {
    cval_t re;
    cval_t im;
  } cplx_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_CALC  = 3'd2,
    S_PASS  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  function automatic int hwidth(input int dwidth);
    return dwidth / 2;
  endfunction

  // Sign-extend the low h bits of w into a full cval_t.
  function automatic cval_t sext(input word_t w, input int h);
    cval_t t;
    t = cval_t'(w);
    t = t <<< (HMAX + 1 - h);
    return t >>> (HMAX + 1 - h);
  endfunction

  function automatic cplx_t cplx_unpack(input word_t w, input int h);
    cplx_t c;
    c.re = sext(w >> h, h);
    c.im = sext(w, h);
    return c;
  endfunction

  function automatic word_t cplx_pack(input cplx_t c, input int h);
    word_t mask;
    mask = (word_t'(1) << h) - word_t'(1);
    return ((word_t'(c.re) & mask) << h) | (word_t'(c.im) & mask);
  endfunction

  // -j * (r + j i) = i - j r; the most negative value negates onto itself.
  function automatic cplx_t rot_mj(input cplx_t x, input int h);
    cplx_t r;
    r.re = x.im;
    if (x.re == -(cval_t'(1) <<< (h - 1))) r.im = x.re;
    else r.im = -x.re;
    return r;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Single-path delay-feedback buffer: a 2^DEPTH_LOG deep shift line that advances only when en is high.
module sdf_delay_line #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH_LOG = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DWIDTH-1:0] i_data,
  output logic [DWIDTH-1:0] o_tail
);
  localparam int D = 1 << DEPTH_LOG;

  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_stage
      logic [DWIDTH-1:0] data_reg;
      logic [DWIDTH-1:0] data_next;
      if (gi == 0) begin : g_head
        assign data_next = i_data;
      end else begin : g_body
        assign data_next = g_stage[gi-1].data_reg;
      end
      always_ff @(posedge clk) begin
        if (reset) data_reg <= '0;
        else if (en) data_reg <= data_next;
      end
    end
  endgenerate

  assign o_tail = g_stage[D-1].data_reg;

endmodule

// File: rtl/bf2ii.sv
// BF2II stage of the R22SDF FFT: butterflies each sample against the one D positions earlier, -j on quarter 3.
// Macro BF2II_SCALE_EN: halve each result (floor); when undefined, results saturate to HWIDTH bits.
module bf2ii
  import fft_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int DEPTH_LOG = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid
);
  localparam int HWIDTH = hwidth(DWIDTH);
  localparam logic [DEPTH_LOG-1:0] LO_LAST = '1;

  state_t               state_reg;
  logic [DEPTH_LOG+1:0] r_idx;
  logic [1:0]           q;
  logic [DEPTH_LOG-1:0] lo;
  logic [DWIDTH-1:0]    m_word;
  logic [DWIDTH-1:0]    sum_word;
  logic [DWIDTH-1:0]    diff_word;
  logic [DWIDTH-1:0]    buf_in;
  logic                 buf_en;
  cplx_t                x;
  cplx_t                xr;
  cplx_t                m;
  cplx_t                sum_c;
  cplx_t                diff_c;

  assign q       = r_idx[DEPTH_LOG+1:DEPTH_LOG];
  assign lo      = r_idx[DEPTH_LOG-1:0];
  assign o_ready = (state_reg != S_FLUSH);

  function automatic cval_t post(input cval_t v);
`ifdef BF2II_SCALE_EN
    return v >>> 1;
`else
    if (v > (cval_t'(1) <<< (HWIDTH - 1)) - cval_t'(1))
      return (cval_t'(1) <<< (HWIDTH - 1)) - cval_t'(1);
    if (v < -(cval_t'(1) <<< (HWIDTH - 1)))
      return -(cval_t'(1) <<< (HWIDTH - 1));
    return v;
`endif
  endfunction

  always_comb begin
    x  = cplx_unpack(word_t'(i_data), HWIDTH);
    m  = cplx_unpack(word_t'(m_word), HWIDTH);
    xr = x;
    if (state_reg == S_CALC && q == 2'd3) xr = rot_mj(x, HWIDTH);
    sum_c.re  = post(m.re + xr.re);
    sum_c.im  = post(m.im + xr.im);
    diff_c.re = post(m.re - xr.re);
    diff_c.im = post(m.im - xr.im);
    sum_word  = DWIDTH'(cplx_pack(sum_c, HWIDTH));
    diff_word = DWIDTH'(cplx_pack(diff_c, HWIDTH));
  end

  // Raw samples enter the line while filling/passing, diffs while calculating, zeros while flushing.
  assign buf_en = (i_valid && o_ready) || (state_reg == S_FLUSH);

  always_comb begin
    buf_in = i_data;
    if (state_reg == S_CALC) buf_in = diff_word;
    else if (state_reg == S_FLUSH) buf_in = '0;
  end

  sdf_delay_line #(
    .DWIDTH   (DWIDTH),
    .DEPTH_LOG(DEPTH_LOG)
  ) u_line (
    .clk   (clk),
    .reset (reset),
    .en    (buf_en),
    .i_data(buf_in),
    .o_tail(m_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      r_idx     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_reg)
        S_IDLE, S_FILL: begin
          if (i_valid) begin
            r_idx     <= r_idx + 1'b1;
            state_reg <= (lo == LO_LAST) ? S_CALC : S_FILL;
          end
        end
        S_CALC: begin
          if (i_valid) begin
            r_idx   <= r_idx + 1'b1;
            o_data  <= sum_word;
            o_valid <= 1'b1;
            if (lo == LO_LAST) state_reg <= S_PASS;
          end
        end
        S_PASS: begin
          if (i_valid) begin
            r_idx   <= r_idx + 1'b1;
            o_data  <= m_word;
            o_valid <= 1'b1;
            if (lo == LO_LAST) state_reg <= S_CALC;
          end else if (lo == '0) begin
            // A gap at a block boundary ends the stream: drain the stored diffs.
            state_reg <= S_FLUSH;
            r_idx     <= '0;
          end
        end
        S_FLUSH: begin
          o_data  <= m_word;
          o_valid <= 1'b1;
          r_idx   <= r_idx + 1'b1;
          if (lo == LO_LAST) begin
            state_reg <= S_IDLE;
            r_idx     <= '0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
